dil_stream_sequencer: RTL and testbench

- Synthesisable, program-driven sequencer for the dilithium core's streaming interface. Replaces hard-coded per-mode load/unload orderings (keygen/sign/verify, high-perf vs low-res) with a run-time segment table.
- Drives core reset and start, then walks the segment list:
  - LOAD segments forward source words into the core.
  - UNLOAD segments compare core output words against an expected stream.
- Records per-segment cycle counts and mismatch statistics. Sits between a host/BIST controller and the dilithium top.

---
 rtl/dil_stream_sequencer_pkg.sv | 27 ++
 rtl/dil_stream_sequencer_seg_table.sv | 47 ++++
 rtl/dil_stream_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_dil_stream_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dil_stream_sequencer_pkg.sv
// Shared types for the dilithium stream sequencer: segment direction,
// sequencer state encoding and the segment table entry layout.
package dil_stream_sequencer_pkg;

   localparam int SEQ_LEN_W = 16;

   typedef enum logic {
      SEG_LOAD   = 1'b0,
      SEG_UNLOAD = 1'b1
   } seg_dir_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_START,
      S_FETCH,
      S_LOAD,
      S_UNLOAD,
      S_DONE
   } seq_state_t;

   typedef struct packed {
      seg_dir_t               dir;
      logic [SEQ_LEN_W-1:0]   len;
   } seg_entry_t;

endpackage

// File: rtl/dil_stream_sequencer_seg_table.sv
// Segment program table (not reset, host-loaded) and per-segment cycle
// result array (cleared on reset), each with one write and one read port.
module dil_seg_table
   import dil_stream_sequencer_pkg::*;
#(
   parameter  int MAX_SEGS = 16,
   parameter  int CYC_W    = 32,
   localparam int AW       = $clog2(MAX_SEGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tbl_we_i,
   input  logic [AW-1:0]    tbl_waddr_i,
   input  seg_entry_t       tbl_wdata_i,
   input  logic [AW-1:0]    tbl_raddr_i,
   output seg_entry_t       tbl_rdata_o,
   input  logic             res_we_i,
   input  logic [AW-1:0]    res_waddr_i,
   input  logic [CYC_W-1:0] res_wdata_i,
   input  logic [AW-1:0]    res_raddr_i,
   output logic [CYC_W-1:0] res_rdata_o
);

   seg_entry_t       tbl_q [MAX_SEGS];
   logic [CYC_W-1:0] res_q [MAX_SEGS];

   // The program survives reset so a BIST controller can rerun it.
   always_ff @(posedge clk) begin
      if (tbl_we_i) begin
         tbl_q[tbl_waddr_i] <= tbl_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_SEGS; i++) begin
            res_q[i] <= '0;
         end
      end else if (res_we_i) begin
         res_q[res_waddr_i] <= res_wdata_i;
      end
   end

   assign tbl_rdata_o = tbl_q[tbl_raddr_i];
   assign res_rdata_o = res_q[res_raddr_i];

endmodule

// File: rtl/dil_stream_sequencer.sv
// Program-driven load/unload sequencer for the dilithium core stream port:
// resets and starts the core, then walks the segment table.
module dil_stream_sequencer
   import dil_stream_sequencer_pkg::*;
#(
   parameter  int W          = 64,
   parameter  int MAX_SEGS   = 16,
   parameter  int LEN_W      = SEQ_LEN_W,
   parameter  int CYC_W      = 32,
   parameter  int RST_CYCLES = 4,
   localparam int AW         = $clog2(MAX_SEGS),
   localparam int NW         = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             prog_we,
   input  logic [AW-1:0]    prog_addr,
   input  logic             prog_dir,
   input  logic [LEN_W-1:0] prog_len,
   input  logic             run,
   input  logic [NW-1:0]    num_segs,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [W-1:0]     src_data,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [W-1:0]     exp_data,
   output logic             core_rst,
   output logic             core_start,
   output logic             core_valid_i,
   input  logic             core_ready_i,
   output logic [W-1:0]     core_data_i,
   input  logic             core_valid_o,
   output logic             core_ready_o,
   input  logic [W-1:0]     core_data_o,
   output logic [LEN_W-1:0] mismatch_cnt,
   output logic [AW-1:0]    first_bad_seg,
   output logic [LEN_W-1:0] first_bad_idx,
   input  logic [AW-1:0]    res_addr,
   output logic [CYC_W-1:0] res_cycles,
   output logic [CYC_W-1:0] total_cycles
);

   localparam int RCW = $clog2(RST_CYCLES + 1);

   seq_state_t       state_q,    state_d;
   logic [RCW-1:0]   rst_cnt_q,  rst_cnt_d;
   logic [NW-1:0]    nseg_q,     nseg_d;
   logic [NW-1:0]    seg_idx_q,  seg_idx_d;
   logic [LEN_W-1:0] len_q,      len_d;
   logic [LEN_W-1:0] idx_q,      idx_d;
   logic [CYC_W-1:0] seg_cyc_q,  seg_cyc_d;
   logic [CYC_W-1:0] total_q,    total_d;
   logic [LEN_W-1:0] mm_cnt_q,   mm_cnt_d;
   logic             bad_seen_q, bad_seen_d;
   logic [AW-1:0]    bad_seg_q,  bad_seg_d;
   logic [LEN_W-1:0] bad_idx_q,  bad_idx_d;

   seg_entry_t       tbl_wdata, tbl_rdata;
   logic             tbl_we;
   logic             res_we;
   logic [CYC_W-1:0] res_wdata;
   logic [CYC_W-1:0] seg_cyc_inc, total_inc;
   logic             in_load, in_unload, ld_beat, ul_beat, last_beat;

   assign tbl_we    = prog_we && (state_q == S_IDLE);
   assign tbl_wdata = '{dir: seg_dir_t'(prog_dir), len: prog_len};

   dil_seg_table #(
      .MAX_SEGS (MAX_SEGS),
      .CYC_W    (CYC_W)
   ) u_tbl (
      .clk         (clk),
      .rst_n       (rst_n),
      .tbl_we_i    (tbl_we),
      .tbl_waddr_i (prog_addr),
      .tbl_wdata_i (tbl_wdata),
      .tbl_raddr_i (seg_idx_q[AW-1:0]),
      .tbl_rdata_o (tbl_rdata),
      .res_we_i    (res_we),
      .res_waddr_i (seg_idx_q[AW-1:0]),
      .res_wdata_i (res_wdata),
      .res_raddr_i (res_addr),
      .res_rdata_o (res_cycles)
   );

   assign seg_cyc_inc = (&seg_cyc_q) ? seg_cyc_q : seg_cyc_q + 1'b1;
   assign total_inc   = (&total_q)   ? total_q   : total_q + 1'b1;

   // Streams are pure wires while a segment is active; no buffering.
   assign in_load      = (state_q == S_LOAD);
   assign in_unload    = (state_q == S_UNLOAD);
   assign core_valid_i = in_load && src_valid;
   assign src_ready    = in_load && core_ready_i;
   assign core_data_i  = in_load ? src_data : '0;
   assign core_ready_o = in_unload && exp_valid;
   assign exp_ready    = in_unload && core_valid_o;
   assign ld_beat      = src_valid && core_ready_i;
   assign ul_beat      = core_valid_o && exp_valid;
   assign last_beat    = (idx_q == len_q - 1'b1);

   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      nseg_d     = nseg_q;
      seg_idx_d  = seg_idx_q;
      len_d      = len_q;
      idx_d      = idx_q;
      seg_cyc_d  = seg_cyc_q;
      total_d    = total_q;
      mm_cnt_d   = mm_cnt_q;
      bad_seen_d = bad_seen_q;
      bad_seg_d  = bad_seg_q;
      bad_idx_d  = bad_idx_q;
      res_we     = 1'b0;
      res_wdata  = seg_cyc_inc;

      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d    = S_RST;
               nseg_d     = (num_segs > NW'(MAX_SEGS)) ? NW'(MAX_SEGS) : num_segs;
               rst_cnt_d  = '0;
               seg_idx_d  = '0;
               seg_cyc_d  = '0;
               total_d    = '0;
               mm_cnt_d   = '0;
               bad_seen_d = 1'b0;
               bad_seg_d  = '0;
               bad_idx_d  = '0;
            end
         end
         S_RST: begin
            if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
               state_d = S_START;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         S_START: begin
            total_d   = '0;
            seg_idx_d = '0;
            state_d   = S_FETCH;
         end
         S_FETCH: begin
            total_d = total_inc;
            if (seg_idx_q == nseg_q) begin
               state_d = S_DONE;
            end else if (tbl_rdata.len == '0) begin
               // Empty segment still costs its fetch cycle.
               res_we    = 1'b1;
               res_wdata = CYC_W'(1);
               seg_idx_d = seg_idx_q + 1'b1;
            end else begin
               len_d     = tbl_rdata.len;
               idx_d     = '0;
               seg_cyc_d = CYC_W'(1);
               state_d   = (tbl_rdata.dir == SEG_UNLOAD) ? S_UNLOAD : S_LOAD;
            end
         end
         S_LOAD, S_UNLOAD: begin
            total_d   = total_inc;
            seg_cyc_d = seg_cyc_inc;
            if (in_load ? ld_beat : ul_beat) begin
               if (in_unload && (core_data_o != exp_data)) begin
                  if (!(&mm_cnt_q)) begin
                     mm_cnt_d = mm_cnt_q + 1'b1;
                  end
                  if (!bad_seen_q) begin
                     bad_seen_d = 1'b1;
                     bad_seg_d  = seg_idx_q[AW-1:0];
                     bad_idx_d  = idx_q;
                  end
               end
               if (last_beat) begin
                  res_we    = 1'b1;
                  seg_idx_d = seg_idx_q + 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort bypasses S_DONE so the host never sees a done for a cancelled run.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rst_cnt_q  <= '0;
         nseg_q     <= '0;
         seg_idx_q  <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         seg_cyc_q  <= '0;
         total_q    <= '0;
         mm_cnt_q   <= '0;
         bad_seen_q <= 1'b0;
         bad_seg_q  <= '0;
         bad_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         nseg_q     <= nseg_d;
         seg_idx_q  <= seg_idx_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         seg_cyc_q  <= seg_cyc_d;
         total_q    <= total_d;
         mm_cnt_q   <= mm_cnt_d;
         bad_seen_q <= bad_seen_d;
         bad_seg_q  <= bad_seg_d;
         bad_idx_q  <= bad_idx_d;
      end
   end

   assign busy          = (state_q == S_RST) || (state_q == S_START) || (state_q == S_FETCH)
                          || in_load || in_unload;
   assign done          = (state_q == S_DONE);
   assign core_rst      = (state_q == S_IDLE) || (state_q == S_RST);
   assign core_start    = (state_q == S_START);
   assign mismatch_cnt  = mm_cnt_q;
   assign first_bad_seg = bad_seg_q;
   assign first_bad_idx = bad_idx_q;
   assign total_cycles  = total_q;

endmodule

// File: tb/tb_dil_stream_sequencer.sv
// Directed bench for dil_stream_sequencer: simple source/core/expected
// stream models plus one task per scenario with hand-computed results.
module tb_dil_stream_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, prog_we, prog_dir, run, abort;
   logic [3:0]  prog_addr, res_addr;
   logic [15:0] prog_len;
   logic [4:0]  num_segs;
   logic        busy, done, src_valid, src_ready, exp_valid, exp_ready;
   logic [63:0] src_data, exp_data, core_data_i, core_data_o;
   logic        core_rst, core_start, core_valid_i, core_ready_i, core_valid_o, core_ready_o;
   logic [15:0] mismatch_cnt, first_bad_idx;
   logic [3:0]  first_bad_seg;
   logic [31:0] res_cycles, total_cycles;

   int vecs = 0, errs = 0;
   int cyc = 0, run_cyc = 0, done_cyc = 0;
   int src_ptr = 0, cout_ptr = 0, exp_ptr = 0;
   bit src_adv, cout_adv, exp_adv;
   int load_n = 0, unl_n = 0, done_n = 0, start_n = 0;
   logic [63:0] load_log [32];
   logic [63:0] src_mem [16];
   logic [63:0] cout_mem [16];
   logic [63:0] exp_mem [16];

   always #5 clk = ~clk;

   dil_stream_sequencer dut (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_dir(prog_dir), .prog_len(prog_len), .run(run), .num_segs(num_segs),
      .abort(abort), .busy(busy), .done(done),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
      .core_rst(core_rst), .core_start(core_start),
      .core_valid_i(core_valid_i), .core_ready_i(core_ready_i), .core_data_i(core_data_i),
      .core_valid_o(core_valid_o), .core_ready_o(core_ready_o), .core_data_o(core_data_o),
      .mismatch_cnt(mismatch_cnt), .first_bad_seg(first_bad_seg), .first_bad_idx(first_bad_idx),
      .res_addr(res_addr), .res_cycles(res_cycles), .total_cycles(total_cycles)
   );

   assign src_data    = src_mem[src_ptr[3:0]];
   assign core_data_o = cout_mem[cout_ptr[3:0]];
   assign exp_data    = exp_mem[exp_ptr[3:0]];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: handshakes and pulses observed mid-cycle.
   always @(negedge clk) begin
      src_adv  = src_valid && src_ready;
      cout_adv = core_valid_o && core_ready_o;
      exp_adv  = exp_valid && exp_ready;
      if (core_valid_i && core_ready_i) begin
         if (load_n < 32) load_log[load_n] = core_data_i;
         load_n++;
      end
      if (core_valid_o && core_ready_o) unl_n++;
      if (done) begin done_n++; done_cyc = cyc; end
      if (core_start) start_n++;
   end

   always @(posedge clk) begin
      #1;
      if (src_adv)  src_ptr++;
      if (cout_adv) cout_ptr++;
      if (exp_adv)  exp_ptr++;
   end

   task automatic clr_logs();
      src_ptr = 0; cout_ptr = 0; exp_ptr = 0;
      load_n = 0; unl_n = 0; done_n = 0; start_n = 0;
   endtask

   task automatic prog(input int a, input logic d, input int l);
      @(posedge clk); #1;
      prog_we = 1'b1; prog_addr = 4'(a); prog_dir = d; prog_len = 16'(l);
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic run_seq(input int n);
      @(posedge clk); #1;
      num_segs = 5'(n); run = 1'b1; run_cyc = cyc;
      @(posedge clk); #1;
      run = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string nm);
      bit got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      vecs++;
      if (!got) begin errs++; $display("FAIL %s_done: no done within %0d cycles, want pulse", nm, budget); end
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      res_addr = 4'd0; #1;
      vecs++;
      if ({busy, done, core_rst, core_start} !== 4'b0010) begin
         errs++; $display("FAIL rst_ctrl: got %b want 0010", {busy, done, core_rst, core_start});
      end
      vecs++;
      if ({core_valid_i, src_ready, core_ready_o, exp_ready} !== 4'b0000) begin
         errs++; $display("FAIL rst_strm: got %b want 0000", {core_valid_i, src_ready, core_ready_o, exp_ready});
      end
      vecs++;
      if ({mismatch_cnt, total_cycles, res_cycles, first_bad_seg, first_bad_idx} !== '0) begin
         errs++; $display("FAIL rst_stat: mm=%0d tot=%0d res=%0d bad=%0d/%0d want all 0",
                          mismatch_cnt, total_cycles, res_cycles, first_bad_seg, first_bad_idx);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_load_unload();
      for (int i = 0; i < 16; i++) begin
         src_mem[i] = 64'(i + 1); cout_mem[i] = 64'(10 + i); exp_mem[i] = 64'(10 + i);
      end
      src_valid = 1'b1; core_ready_i = 1'b1; core_valid_o = 1'b1; exp_valid = 1'b1;
      prog(0, 1'b0, 4);
      prog(1, 1'b1, 3);
      clr_logs();
      run_seq(2);
      wait_done(80, "lu");
      vecs++;
      if (load_n !== 4) begin errs++; $display("FAIL lu_nload: got %0d want 4", load_n); end
      for (int i = 0; i < 4; i++) begin
         vecs++;
         if (load_log[i] !== 64'(i + 1)) begin
            errs++; $display("FAIL lu_word%0d: got %h want %h", i, load_log[i], 64'(i + 1));
         end
      end
      vecs++;
      if (unl_n !== 3) begin errs++; $display("FAIL lu_nunl: got %0d want 3", unl_n); end
      vecs++;
      if (mismatch_cnt !== 16'd0) begin errs++; $display("FAIL lu_mm: got %0d want 0", mismatch_cnt); end
      res_addr = 4'd0; #1;
      vecs++;
      if (res_cycles !== 32'd5) begin errs++; $display("FAIL lu_res0: got %0d want 5", res_cycles); end
      res_addr = 4'd1; #1;
      vecs++;
      if (res_cycles !== 32'd4) begin errs++; $display("FAIL lu_res1: got %0d want 4", res_cycles); end
      vecs++;
      if (total_cycles !== 32'd10) begin errs++; $display("FAIL lu_total: got %0d want 10", total_cycles); end
      vecs++;
      if (done_n !== 1 || busy !== 1'b0) begin
         errs++; $display("FAIL lu_donecnt: done=%0d busy=%b want 1/0", done_n, busy);
      end
   endtask

   task automatic test_mismatch();
      exp_mem[1] = 64'hFF;
      clr_logs();
      run_seq(2);
      wait_done(80, "mm");
      vecs++;
      if (mismatch_cnt !== 16'd1) begin errs++; $display("FAIL mm_cnt: got %0d want 1", mismatch_cnt); end
      vecs++;
      if (first_bad_seg !== 4'd1 || first_bad_idx !== 16'd1) begin
         errs++; $display("FAIL mm_loc: got seg %0d idx %0d want 1/1", first_bad_seg, first_bad_idx);
      end
      exp_mem[1] = 64'd11;
   endtask

   task automatic test_backpressure();
      bit seen = 1'b0;
      bit got = 1'b0;
      for (int i = 0; i < 16; i++) src_mem[i] = 64'h100 + 64'(i);
      core_ready_i = 1'b0;
      prog(0, 1'b0, 8);
      clr_logs();
      run_seq(1);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (core_start) seen = 1'b1;
      end
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         core_ready_i = (k > 0) && (k % 2 == 0);
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      vecs++;
      if (!(seen && got)) begin errs++; $display("FAIL bp_done: start=%b done=%b want 1/1", seen, got); end
      @(negedge clk);
      core_ready_i = 1'b1;
      vecs++;
      if (load_n !== 8) begin errs++; $display("FAIL bp_nload: got %0d want 8", load_n); end
      for (int i = 0; i < 8; i++) begin
         vecs++;
         if (load_log[i] !== 64'h100 + 64'(i)) begin
            errs++; $display("FAIL bp_word%0d: got %h want %h", i, load_log[i], 64'h100 + 64'(i));
         end
      end
      res_addr = 4'd0; #1;
      vecs++;
      if (res_cycles !== 32'd17) begin errs++; $display("FAIL bp_res0: got %0d want 17", res_cycles); end
      vecs++;
      if (total_cycles !== 32'd18) begin errs++; $display("FAIL bp_total: got %0d want 18", total_cycles); end
      vecs++;
      if (mismatch_cnt !== 16'd0) begin errs++; $display("FAIL bp_mmclr: got %0d want 0", mismatch_cnt); end
   endtask

   task automatic test_zero_segs();
      clr_logs();
      run_seq(0);
      wait_done(40, "z0");
      vecs++;
      if (done_cyc - run_cyc !== 7) begin
         errs++; $display("FAIL z0_lat: got %0d want 7", done_cyc - run_cyc);
      end
      vecs++;
      if (start_n !== 1) begin errs++; $display("FAIL z0_start: got %0d want 1", start_n); end
      vecs++;
      if (load_n + unl_n !== 0) begin errs++; $display("FAIL z0_hs: got %0d want 0", load_n + unl_n); end
      vecs++;
      if (total_cycles !== 32'd1) begin errs++; $display("FAIL z0_total: got %0d want 1", total_cycles); end
   endtask

   task automatic test_zero_len();
      prog(0, 1'b0, 0);
      prog(1, 1'b1, 2);
      clr_logs();
      run_seq(2);
      wait_done(60, "zl");
      res_addr = 4'd0; #1;
      vecs++;
      if (res_cycles !== 32'd1) begin errs++; $display("FAIL zl_res0: got %0d want 1", res_cycles); end
      res_addr = 4'd1; #1;
      vecs++;
      if (res_cycles !== 32'd3) begin errs++; $display("FAIL zl_res1: got %0d want 3", res_cycles); end
      vecs++;
      if (unl_n !== 2 || load_n !== 0) begin
         errs++; $display("FAIL zl_hs: got unl %0d load %0d want 2/0", unl_n, load_n);
      end
      vecs++;
      if (total_cycles !== 32'd5) begin errs++; $display("FAIL zl_total: got %0d want 5", total_cycles); end
   endtask

   task automatic test_abort();
      bit got = 1'b0;
      prog(0, 1'b1, 6);
      clr_logs();
      run_seq(1);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (core_ready_o) begin got = 1'b1; break; end
      end
      vecs++;
      if (!got) begin errs++; $display("FAIL ab_unl: unload never reached, want reached"); end
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      vecs++;
      if ({busy, core_rst} !== 2'b01) begin errs++; $display("FAIL ab_ctrl: got %b want 01", {busy, core_rst}); end
      vecs++;
      if ({core_valid_i, src_ready, core_ready_o, exp_ready} !== 4'b0000) begin
         errs++; $display("FAIL ab_strm: got %b want 0000", {core_valid_i, src_ready, core_ready_o, exp_ready});
      end
      vecs++;
      if (unl_n !== 2) begin errs++; $display("FAIL ab_beats: got %0d want 2", unl_n); end
      repeat (10) @(negedge clk);
      vecs++;
      if (done_n !== 0) begin errs++; $display("FAIL ab_nodone: got %0d want 0", done_n); end
      clr_logs();
      run_seq(1);
      wait_done(60, "ab2");
      vecs++;
      if (unl_n !== 6 || mismatch_cnt !== 16'd0) begin
         errs++; $display("FAIL ab_rerun: got unl %0d mm %0d want 6/0", unl_n, mismatch_cnt);
      end
      res_addr = 4'd0; #1;
      vecs++;
      if (res_cycles !== 32'd7) begin errs++; $display("FAIL ab_res0: got %0d want 7", res_cycles); end
   endtask

   task automatic test_clamp();
      for (int i = 0; i < 16; i++) prog(i, 1'b0, 0);
      clr_logs();
      run_seq(31);
      prog(2, 1'b0, 5);
      wait_done(80, "cl");
      vecs++;
      if (total_cycles !== 32'd17) begin errs++; $display("FAIL cl_total: got %0d want 17", total_cycles); end
      vecs++;
      if (load_n !== 0) begin errs++; $display("FAIL cl_busywr: got %0d loads want 0", load_n); end
      res_addr = 4'd15; #1;
      vecs++;
      if (res_cycles !== 32'd1) begin errs++; $display("FAIL cl_res15: got %0d want 1", res_cycles); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; prog_we = 1'b0; prog_dir = 1'b0; prog_addr = '0; prog_len = '0;
      run = 1'b0; num_segs = '0; abort = 1'b0; res_addr = '0;
      src_valid = 1'b0; exp_valid = 1'b0; core_ready_i = 1'b0; core_valid_o = 1'b0;
      for (int i = 0; i < 16; i++) begin src_mem[i] = '0; cout_mem[i] = '0; exp_mem[i] = '0; end
      test_reset();
      test_load_unload();
      test_mismatch();
      test_backpressure();
      test_zero_segs();
      test_zero_len();
      test_abort();
      test_clamp();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
